zap_thumb_halfword_sequencer: RTL and testbench
===============================================

# zap_thumb_halfword_sequencer

Sits between the I-cache/fetch stage and the Thumb decoder stage. It splits each fetched 32-bit word into two 16-bit Thumb halfwords and delivers them one per cycle, holding fetch off while the second halfword is pending. In ARM state (T=0) it passes whole words through. It resolves the core's stall/clear priority chain locally, so its pipeline register obeys the same rules as every other stage.

## Interface
Parameters: none.

- i_clk  in  1  clock
- i_reset  in  1  reset, synchronous, active-high
- i_clear_from_writeback, i_data_stall, i_clear_from_alu  in  1 each  pipeline controls, priority 1..3
- i_stall_from_shifter, i_stall_from_issue, i_stall_from_decode  in  1 each  priority 4 (OR'd)
- i_clear_from_decode  in  1  priority 5
- i_cpsr_ff_t  in  1  Thumb state
- i_instruction  in  32  fetched word
- i_instruction_valid  in  1  word qualifier
- i_iabort  in  1  fetch abort for this word
- i_pc_ff  in  32  fetch address; bit 1 selects the first halfword in Thumb
- i_irq, i_fiq  in  1 each  level interrupts
- o_fetch_stall  out  1  combinational; fetch must hold i_instruction/i_pc_ff
- o_instruction  out  32  Thumb: {16'd0, halfword}; ARM: word
- o_instruction_valid  out  1
- o_iabort, o_irq, o_fiq  out  1 each
- o_pc_ff  out  32  address of the emitted instruction
- o_pc_plus_8_ff  out  32  o_pc_ff+4 (Thumb) or +8 (ARM), modulo 2^32

## Operation
- Priority decode per cycle, highest first:
  - CLR_HI (i_clear_from_writeback)
  - HOLD_HI (i_data_stall)
  - CLR_MID (i_clear_from_alu)
  - HOLD_LO (any shifter/issue/decode stall)
  - CLR_LO (i_clear_from_decode)
  - ADVANCE otherwise
- CLEAR (any CLR level):
  - o_instruction_valid, o_iabort, o_irq and o_fiq go to 0.
  - State goes to EMPTY and the buffered word is discarded.
  - Data/PC outputs keep their old values.
- HOLD: all registers and state are unchanged.
- ADVANCE, state EMPTY:
  - Input not valid: o_instruction_valid goes to 0.
  - ARM (T=0): emit the word, pc=i_pc_ff.
  - Thumb with i_iabort=1: emit one entry, o_iabort=1, o_instruction=0, pc=i_pc_ff. No PENDING.
  - Thumb with i_pc_ff[1]=1: emit i_instruction[31:16], pc=i_pc_ff. Stay EMPTY.
  - Thumb with i_pc_ff[1]=0: emit i_instruction[15:0], pc=i_pc_ff. Latch word[31:16] and pc+2 into the buffer, then go to PENDING.
- ADVANCE, state PENDING:
  - Emit the buffered halfword at the buffered pc, with valid=1 and iabort=0.
  - Go to EMPTY.
  - The input word is not consumed.
  - A T change while PENDING without a clear does not drop the halfword. T changes only through a flush.
- o_irq/o_fiq = i_irq/i_fiq sampled on every emitting ADVANCE.
- o_fetch_stall = HOLD_HI | HOLD_LO | (ADVANCE & state==PENDING). It is 0 during any CLEAR.
- Address arithmetic: 32-bit, wrap-around permitted (0xFFFF_FFFC+2 = 0xFFFF_FFFE; its plus_8 is 0x0000_0002).

## Timing
- Reset values:
  - All outputs 0 (o_instruction=0, pcs=0, valid/iabort/irq/fiq=0).
  - State EMPTY, buffer 0.
  - o_fetch_stall is 0 during reset.
- Latency: 1 cycle from an accepted input to the registered output.
- Thumb throughput:
  - Aligned word: 2 halfwords in 2 consecutive ADVANCE cycles, with o_fetch_stall high during the second.
  - Unaligned entry (pc[1]=1): 1 halfword per word.
- Reset or a clear while PENDING: the pending halfword is lost, and fetch resumes the next cycle.
- A HOLD while PENDING preserves PENDING. The halfword emits on the first subsequent ADVANCE.
- A clear and a stall in the same cycle resolve by the priority list; e.g. data stall + clear_from_alu is a HOLD.

## Structure
- zap_localparams.svh / shared package holds:
  - typedef enum {SEQ_EMPTY, SEQ_PENDING} for the state.
  - Localparams THUMB_PC_INC=2, THUMB_PC_PLUS=4, ARM_PC_PLUS=8.
- Sub-module zap_pipe_ctrl_prio: combinational, maps the seven control inputs to one-hot {clear, hold, advance}. It is reusable by other stages.
- Target ~150–250 lines of RTL.

## Test plan
- Thumb, word 0xB4F0_2001 at pc 0x100, no stalls:
  - Outputs 0x2001 @0x100 (plus8=0x104), then 0xB4F0 @0x102.
  - o_fetch_stall=1 during the second cycle.
- Thumb, pc 0x202, word 0x4770_0000 → single output 0x4770 @0x202. No fetch stall.
- PENDING, then i_data_stall for 3 cycles → outputs frozen and o_fetch_stall=1. The high halfword emits on the 4th cycle.
- PENDING + i_clear_from_alu → valid=0 next cycle, state EMPTY. The next input word emits its low half.
- i_iabort=1 at pc 0x300, Thumb → one entry with o_iabort=1, o_instruction=0. Then the next word is accepted immediately.
- ARM, word 0xE3A0_0001 at 0xFFFF_FFFC → o_pc_plus_8_ff=0x0000_0004. Reset mid-PENDING returns all outputs to 0.

Source files
------------

// File: rtl/zap_thumb_halfword_sequencer_pkg.sv
// Shared types and constants for the Thumb halfword sequencer stage.
// Holds the sequencer state encoding and the PC increment constants.
// Imported by the sequencer top; the priority decoder needs none of it.
package zap_thumb_halfword_sequencer_pkg;

  typedef enum logic {
    SEQ_EMPTY   = 1'b0,
    SEQ_PENDING = 1'b1
  } seq_state_t;

  localparam logic [31:0] THUMB_PC_INC  = 32'd2;
  localparam logic [31:0] THUMB_PC_PLUS = 32'd4;
  localparam logic [31:0] ARM_PC_PLUS   = 32'd8;

endpackage

// File: rtl/zap_pipe_ctrl_prio.sv
// Purpose: resolve the core's clear/stall priority chain into one-hot clear/hold/advance.
// Latency: purely combinational.
// Backpressure: o_hold marks a stall level winning; the stage keeps its registers.
module zap_pipe_ctrl_prio (
  input  logic i_clear_from_writeback,
  input  logic i_data_stall,
  input  logic i_clear_from_alu,
  input  logic i_stall_from_shifter,
  input  logic i_stall_from_issue,
  input  logic i_stall_from_decode,
  input  logic i_clear_from_decode,
  output logic o_clear,
  output logic o_hold,
  output logic o_advance
);

  logic any_lo_stall;

  // Walk the priority list top-down; exactly one output is asserted.
  always_comb begin
    any_lo_stall = i_stall_from_shifter | i_stall_from_issue | i_stall_from_decode;
    o_clear      = 1'b0;
    o_hold       = 1'b0;
    o_advance    = 1'b0;
    if (i_clear_from_writeback)  o_clear   = 1'b1;
    else if (i_data_stall)       o_hold    = 1'b1;
    else if (i_clear_from_alu)   o_clear   = 1'b1;
    else if (any_lo_stall)       o_hold    = 1'b1;
    else if (i_clear_from_decode) o_clear  = 1'b1;
    else                         o_advance = 1'b1;
  end

endmodule

// File: rtl/zap_thumb_halfword_sequencer.sv
// Purpose: split fetched words into Thumb halfwords (or pass ARM words) for decode.
// Latency: 1 cycle from an accepted input to the registered output.
// Backpressure: o_fetch_stall holds fetch on any stall and while a buffered halfword drains.
module zap_thumb_halfword_sequencer
  import zap_thumb_halfword_sequencer_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_clear_from_writeback,
  input  logic        i_data_stall,
  input  logic        i_clear_from_alu,
  input  logic        i_stall_from_shifter,
  input  logic        i_stall_from_issue,
  input  logic        i_stall_from_decode,
  input  logic        i_clear_from_decode,
  input  logic        i_cpsr_ff_t,
  input  logic [31:0] i_instruction,
  input  logic        i_instruction_valid,
  input  logic        i_iabort,
  input  logic [31:0] i_pc_ff,
  input  logic        i_irq,
  input  logic        i_fiq,
  output logic        o_fetch_stall,
  output logic [31:0] o_instruction,
  output logic        o_instruction_valid,
  output logic        o_iabort,
  output logic        o_irq,
  output logic        o_fiq,
  output logic [31:0] o_pc_ff,
  output logic [31:0] o_pc_plus_8_ff
);

  logic clear, hold, advance;

  seq_state_t  state_q, state_d;
  logic [15:0] buf_hw_q, buf_hw_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc8_q, pc8_d;
  logic        valid_q, valid_d;
  logic        iabort_q, iabort_d;
  logic        irq_q, irq_d;
  logic        fiq_q, fiq_d;

  zap_pipe_ctrl_prio u_prio (
    .i_clear_from_writeback (i_clear_from_writeback),
    .i_data_stall           (i_data_stall),
    .i_clear_from_alu       (i_clear_from_alu),
    .i_stall_from_shifter   (i_stall_from_shifter),
    .i_stall_from_issue     (i_stall_from_issue),
    .i_stall_from_decode    (i_stall_from_decode),
    .i_clear_from_decode    (i_clear_from_decode),
    .o_clear                (clear),
    .o_hold                 (hold),
    .o_advance              (advance)
  );

  // Pipeline register and halfword buffer; synchronous reset clears everything.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= SEQ_EMPTY;
      buf_hw_q <= '0;
      buf_pc_q <= '0;
      instr_q  <= '0;
      pc_q     <= '0;
      pc8_q    <= '0;
      valid_q  <= 1'b0;
      iabort_q <= 1'b0;
      irq_q    <= 1'b0;
      fiq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      buf_hw_q <= buf_hw_d;
      buf_pc_q <= buf_pc_d;
      instr_q  <= instr_d;
      pc_q     <= pc_d;
      pc8_q    <= pc8_d;
      valid_q  <= valid_d;
      iabort_q <= iabort_d;
      irq_q    <= irq_d;
      fiq_q    <= fiq_d;
    end
  end

  // Next-state: a clear kills qualifiers but keeps data/pc; a hold keeps everything.
  always_comb begin
    state_d  = state_q;
    buf_hw_d = buf_hw_q;
    buf_pc_d = buf_pc_q;
    instr_d  = instr_q;
    pc_d     = pc_q;
    pc8_d    = pc8_q;
    valid_d  = valid_q;
    iabort_d = iabort_q;
    irq_d    = irq_q;
    fiq_d    = fiq_q;

    if (clear) begin
      state_d  = SEQ_EMPTY;
      valid_d  = 1'b0;
      iabort_d = 1'b0;
      irq_d    = 1'b0;
      fiq_d    = 1'b0;
    end else if (advance) begin
      valid_d  = 1'b1;
      iabort_d = 1'b0;
      irq_d    = i_irq;
      fiq_d    = i_fiq;
      if (state_q == SEQ_PENDING) begin
        // Drain the buffered high halfword; the input word is left untouched.
        instr_d = {16'd0, buf_hw_q};
        pc_d    = buf_pc_q;
        pc8_d   = buf_pc_q + THUMB_PC_PLUS;
        state_d = SEQ_EMPTY;
      end else if (!i_instruction_valid) begin
        valid_d = 1'b0;
        irq_d   = 1'b0;
        fiq_d   = 1'b0;
      end else if (!i_cpsr_ff_t) begin
        instr_d  = i_instruction;
        pc_d     = i_pc_ff;
        pc8_d    = i_pc_ff + ARM_PC_PLUS;
        iabort_d = i_iabort;
      end else if (i_iabort) begin
        // An aborted fetch produces one abort entry, never a second halfword.
        instr_d  = '0;
        pc_d     = i_pc_ff;
        pc8_d    = i_pc_ff + THUMB_PC_PLUS;
        iabort_d = 1'b1;
      end else if (i_pc_ff[1]) begin
        instr_d = {16'd0, i_instruction[31:16]};
        pc_d    = i_pc_ff;
        pc8_d   = i_pc_ff + THUMB_PC_PLUS;
      end else begin
        instr_d  = {16'd0, i_instruction[15:0]};
        pc_d     = i_pc_ff;
        pc8_d    = i_pc_ff + THUMB_PC_PLUS;
        buf_hw_d = i_instruction[31:16];
        buf_pc_d = i_pc_ff + THUMB_PC_INC;
        state_d  = SEQ_PENDING;
      end
    end
  end

  assign o_fetch_stall       = ~i_reset & (hold | (advance & (state_q == SEQ_PENDING)));
  assign o_instruction       = instr_q;
  assign o_instruction_valid = valid_q;
  assign o_iabort            = iabort_q;
  assign o_irq               = irq_q;
  assign o_fiq               = fiq_q;
  assign o_pc_ff             = pc_q;
  assign o_pc_plus_8_ff      = pc8_q;

endmodule

// File: tb/tb_zap_thumb_halfword_sequencer.sv
// Self-checking bench for the Thumb halfword sequencer.
// Directed scenarios followed by randomized traffic against a queue-based reference model.
module tb_zap_thumb_halfword_sequencer;

  logic        i_clk;
  logic        i_reset;
  logic        i_clear_from_writeback, i_data_stall, i_clear_from_alu;
  logic        i_stall_from_shifter, i_stall_from_issue, i_stall_from_decode;
  logic        i_clear_from_decode;
  logic        i_cpsr_ff_t;
  logic [31:0] i_instruction;
  logic        i_instruction_valid;
  logic        i_iabort;
  logic [31:0] i_pc_ff;
  logic        i_irq, i_fiq;
  logic        o_fetch_stall;
  logic [31:0] o_instruction;
  logic        o_instruction_valid;
  logic        o_iabort, o_irq, o_fiq;
  logic [31:0] o_pc_ff, o_pc_plus_8_ff;

  zap_thumb_halfword_sequencer dut (
    .i_clk                  (i_clk),
    .i_reset                (i_reset),
    .i_clear_from_writeback (i_clear_from_writeback),
    .i_data_stall           (i_data_stall),
    .i_clear_from_alu       (i_clear_from_alu),
    .i_stall_from_shifter   (i_stall_from_shifter),
    .i_stall_from_issue     (i_stall_from_issue),
    .i_stall_from_decode    (i_stall_from_decode),
    .i_clear_from_decode    (i_clear_from_decode),
    .i_cpsr_ff_t            (i_cpsr_ff_t),
    .i_instruction          (i_instruction),
    .i_instruction_valid    (i_instruction_valid),
    .i_iabort               (i_iabort),
    .i_pc_ff                (i_pc_ff),
    .i_irq                  (i_irq),
    .i_fiq                  (i_fiq),
    .o_fetch_stall          (o_fetch_stall),
    .o_instruction          (o_instruction),
    .o_instruction_valid    (o_instruction_valid),
    .o_iabort               (o_iabort),
    .o_irq                  (o_irq),
    .o_fiq                  (o_fiq),
    .o_pc_ff                (o_pc_ff),
    .o_pc_plus_8_ff         (o_pc_plus_8_ff)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  int checks   = 0;
  int failures = 0;

  // Reference model: halfwords still owed to decode, in delivery order.
  typedef struct {
    logic [15:0] hw;
    logic [31:0] pc;
  } hw_t;
  hw_t owed_q[$];

  logic [31:0] e_instr, e_pc, e_pc8;
  logic        e_valid, e_iabort, e_irq, e_fiq, e_fs, e_side;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic m_emit(input logic [31:0] ins, input logic [31:0] pc,
                        input logic [31:0] pc8, input logic ab);
    e_instr  = ins;
    e_pc     = pc;
    e_pc8    = pc8;
    e_valid  = 1'b1;
    e_iabort = ab;
    e_irq    = i_irq;
    e_fiq    = i_fiq;
    e_side   = 1'b1;
  endtask

  task automatic set_in(input logic t, input logic [31:0] w, input logic [31:0] pc,
                        input logic vld, input logic ab);
    i_cpsr_ff_t            = t;
    i_instruction          = w;
    i_pc_ff                = pc;
    i_instruction_valid    = vld;
    i_iabort               = ab;
    i_clear_from_writeback = 1'b0;
    i_data_stall           = 1'b0;
    i_clear_from_alu       = 1'b0;
    i_stall_from_shifter   = 1'b0;
    i_stall_from_issue     = 1'b0;
    i_stall_from_decode    = 1'b0;
    i_clear_from_decode    = 1'b0;
  endtask

  // One clock: check fetch stall on the current inputs, update the model, check outputs.
  task automatic step(input string tag);
    logic clr, hld, adv;
    hw_t  ent;
    #2;
    clr = 1'b0; hld = 1'b0; adv = 1'b0;
    if (i_clear_from_writeback) clr = 1'b1;
    else if (i_data_stall) hld = 1'b1;
    else if (i_clear_from_alu) clr = 1'b1;
    else if (i_stall_from_shifter || i_stall_from_issue || i_stall_from_decode) hld = 1'b1;
    else if (i_clear_from_decode) clr = 1'b1;
    else adv = 1'b1;
    e_fs = !i_reset && (hld || (adv && owed_q.size() != 0));
    chk($sformatf("%s.fetch_stall", tag), {31'd0, o_fetch_stall}, {31'd0, e_fs});

    if (i_reset) begin
      owed_q.delete();
      e_instr = '0; e_pc = '0; e_pc8 = '0;
      e_valid = 1'b0; e_iabort = 1'b0; e_irq = 1'b0; e_fiq = 1'b0; e_side = 1'b1;
    end else if (clr) begin
      owed_q.delete();
      e_valid = 1'b0; e_iabort = 1'b0; e_irq = 1'b0; e_fiq = 1'b0; e_side = 1'b1;
    end else if (adv) begin
      if (owed_q.size() != 0) begin
        ent = owed_q.pop_front();
        m_emit({16'd0, ent.hw}, ent.pc, ent.pc + 32'd4, 1'b0);
      end else if (!i_instruction_valid) begin
        e_valid = 1'b0;
        e_side  = 1'b0;
      end else if (!i_cpsr_ff_t) begin
        m_emit(i_instruction, i_pc_ff, i_pc_ff + 32'd8, i_iabort);
      end else if (i_iabort) begin
        m_emit(32'd0, i_pc_ff, i_pc_ff + 32'd4, 1'b1);
      end else if (i_pc_ff[1]) begin
        m_emit({16'd0, i_instruction[31:16]}, i_pc_ff, i_pc_ff + 32'd4, 1'b0);
      end else begin
        m_emit({16'd0, i_instruction[15:0]}, i_pc_ff, i_pc_ff + 32'd4, 1'b0);
        ent.hw = i_instruction[31:16];
        ent.pc = i_pc_ff + 32'd2;
        owed_q.push_back(ent);
      end
    end

    @(posedge i_clk);
    #1;
    chk($sformatf("%s.valid", tag), {31'd0, o_instruction_valid}, {31'd0, e_valid});
    chk($sformatf("%s.instr", tag), o_instruction, e_instr);
    chk($sformatf("%s.pc", tag), o_pc_ff, e_pc);
    chk($sformatf("%s.pc8", tag), o_pc_plus_8_ff, e_pc8);
    if (e_side) begin
      chk($sformatf("%s.iabort", tag), {31'd0, o_iabort}, {31'd0, e_iabort});
      chk($sformatf("%s.irq", tag), {31'd0, o_irq}, {31'd0, e_irq});
      chk($sformatf("%s.fiq", tag), {31'd0, o_fiq}, {31'd0, e_fiq});
    end
  endtask

  initial begin
    i_irq = 1'b0;
    i_fiq = 1'b0;
    set_in(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    i_reset = 1'b1;
    e_instr = '0; e_pc = '0; e_pc8 = '0;
    e_valid = 1'b0; e_iabort = 1'b0; e_irq = 1'b0; e_fiq = 1'b0; e_fs = 1'b0; e_side = 1'b1;
    @(posedge i_clk);
    #1;
    step("reset0");
    step("reset1");
    i_reset = 1'b0;
    step("idle");

    // Aligned Thumb word: low half, then high half with fetch held.
    set_in(1'b1, 32'hB4F0_2001, 32'h100, 1'b1, 1'b0);
    step("tp1_lo");
    chk("tp1_lo_const", o_instruction, 32'h0000_2001);
    chk("tp1_lo_pc8", o_pc_plus_8_ff, 32'h104);
    step("tp1_hi");
    chk("tp1_hi_const", o_instruction, 32'h0000_B4F0);
    chk("tp1_hi_pc", o_pc_ff, 32'h102);

    // Unaligned entry: single halfword, no stall.
    set_in(1'b1, 32'h4770_0000, 32'h202, 1'b1, 1'b0);
    step("tp2");
    chk("tp2_const", o_instruction, 32'h0000_4770);

    // Data stall while pending holds for three cycles, then drains.
    set_in(1'b1, 32'h1111_2222, 32'h204, 1'b1, 1'b0);
    step("tp3_lo");
    i_data_stall = 1'b1;
    step("tp3_hold0");
    step("tp3_hold1");
    step("tp3_hold2");
    chk("tp3_frozen", o_instruction, 32'h0000_2222);
    i_data_stall = 1'b0;
    step("tp3_hi");
    chk("tp3_hi_const", o_instruction, 32'h0000_1111);

    // Clear from ALU while pending drops the halfword.
    set_in(1'b1, 32'h3333_4444, 32'h208, 1'b1, 1'b0);
    step("tp4_lo");
    i_clear_from_alu = 1'b1;
    step("tp4_clr");
    set_in(1'b1, 32'h5555_6666, 32'h20C, 1'b1, 1'b0);
    step("tp4_next");
    chk("tp4_next_const", o_instruction, 32'h0000_6666);

    // Data stall outranks clear from ALU; priority-1 clear then flushes.
    i_data_stall = 1'b1;
    i_clear_from_alu = 1'b1;
    step("prio_hold");
    set_in(1'b1, 32'h5555_6666, 32'h20C, 1'b1, 1'b0);
    i_clear_from_writeback = 1'b1;
    i_data_stall = 1'b1;
    step("prio_wb");

    // Thumb fetch abort produces one entry and the next word is taken at once.
    i_irq = 1'b1;
    set_in(1'b1, 32'hDEAD_BEEF, 32'h300, 1'b1, 1'b1);
    step("tp5_abort");
    chk("tp5_abort_flag", {31'd0, o_iabort}, 32'd1);
    i_irq = 1'b0;
    i_fiq = 1'b1;
    set_in(1'b1, 32'h7777_8888, 32'h304, 1'b1, 1'b0);
    step("tp5_next");
    i_fiq = 1'b0;
    step("tp5_next_hi");

    // ARM pass-through with address wrap.
    set_in(1'b0, 32'hE3A0_0001, 32'hFFFF_FFFC, 1'b1, 1'b0);
    step("tp6_arm");
    chk("tp6_pc8_const", o_pc_plus_8_ff, 32'h0000_0004);

    // Thumb wrap on the second halfword.
    set_in(1'b1, 32'hAAAA_BBBB, 32'hFFFF_FFFC, 1'b1, 1'b0);
    step("wrap_lo");
    step("wrap_hi");
    chk("wrap_pc_const", o_pc_ff, 32'hFFFF_FFFE);
    chk("wrap_pc8_const", o_pc_plus_8_ff, 32'h0000_0002);

    // Reset while pending clears all outputs.
    set_in(1'b1, 32'hCCCC_DDDD, 32'h400, 1'b1, 1'b0);
    step("rstp_lo");
    i_reset = 1'b1;
    step("rstp_rst");
    chk("rstp_instr_const", o_instruction, 32'd0);
    i_reset = 1'b0;
    step("rstp_idle");

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      set_in(1'($urandom_range(0, 1)), $urandom(),
             {$urandom_range(0, 32'h3FFF_FFFF), 1'($urandom_range(0, 1)), 1'b0},
             ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0));
      i_clear_from_writeback = ($urandom_range(0, 19) == 0);
      i_data_stall           = ($urandom_range(0, 9) == 0);
      i_clear_from_alu       = ($urandom_range(0, 14) == 0);
      i_stall_from_shifter   = ($urandom_range(0, 19) == 0);
      i_stall_from_issue     = ($urandom_range(0, 19) == 0);
      i_stall_from_decode    = ($urandom_range(0, 19) == 0);
      i_clear_from_decode    = ($urandom_range(0, 14) == 0);
      i_irq                  = 1'($urandom_range(0, 1));
      i_fiq                  = 1'($urandom_range(0, 1));
      i_reset                = ($urandom_range(0, 49) == 0);
      step($sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
